// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition
// selectors and status codes used across the pipeline stages.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions (the ifun field of OPq)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition selectors (the ifun field of jXX / cmovXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Status codes
  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  // "No register" marker for destination fields
  localparam logic [3:0] RNONE = 4'hF;

  // True when a status denotes an exception (halt, bad address, bad instruction)
  function automatic logic is_exception(input logic [3:0] stat);
    is_exception = (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/execute_stage_alu64.sv
// Combinational Y86-64 ALU: computes B op A and the ZF/SF/OF flags of the
// result. Unknown function codes give a zero result with OF clear.
module alu64
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alufun,
  output logic [DATA_W-1:0] res,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  logic [DATA_W-1:0] res_s;
  logic              of_s;

  // Result and signed overflow for the selected function
  always_comb begin
    res_s = {DATA_W{1'b0}};
    of_s  = 1'b0;
    case (alufun)
      ALU_ADD: begin
        res_s = alu_b + alu_a;
        of_s  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                (res_s[DATA_W-1] != alu_a[DATA_W-1]);
      end
      ALU_SUB: begin
        res_s = alu_b - alu_a;
        of_s  = (alu_b[DATA_W-1] != alu_a[DATA_W-1]) &&
                (res_s[DATA_W-1] != alu_b[DATA_W-1]);
      end
      ALU_AND: begin
        res_s = alu_b & alu_a;
        of_s  = 1'b0;
      end
      ALU_XOR: begin
        res_s = alu_b ^ alu_a;
        of_s  = 1'b0;
      end
      default: begin
        res_s = {DATA_W{1'b0}};
        of_s  = 1'b0;
      end
    endcase
  end

  assign res = res_s;
  assign zf  = (res_s == {DATA_W{1'b0}});
  assign sf  = res_s[DATA_W-1];
  assign of  = of_s;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, architectural condition
// codes and branch/cmov condition evaluation. CC is the only state.
module execute_stage
  import y86_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_ValC,
  input  logic [DATA_W-1:0] E_ValA,
  input  logic [DATA_W-1:0] E_ValB,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        W_stat,
  output logic [DATA_W-1:0] e_ValE,
  output logic [DATA_W-1:0] e_ValA,
  output logic              e_Cnd,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM,
  output logic [3:0]        e_stat,
  output logic [3:0]        e_icode,
  output logic [2:0]        CC
);

  // Stack pointer adjustment constants
  localparam logic [DATA_W-1:0] NEG8 = {{(DATA_W-4){1'b1}}, 4'b1000};
  localparam logic [DATA_W-1:0] POS8 = {{(DATA_W-4){1'b0}}, 4'b1000};

  logic [DATA_W-1:0] alu_a_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [3:0]        alufun_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              zf_s;
  logic              sf_s;
  logic              of_s;
  logic              set_cc_s;
  logic              cnd_s;
  logic [2:0]        cc_r;

  // ALU operand A: register value, constant, or +/-8 for stack operations
  always_comb begin
    alu_a_s = {DATA_W{1'b0}};
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a_s = E_ValA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = E_ValC;
      I_CALL, I_PUSHQ:             alu_a_s = NEG8;
      I_RET, I_POPQ:               alu_a_s = POS8;
      default:                     alu_a_s = {DATA_W{1'b0}};
    endcase
  end

  // ALU operand B: base register for memory/stack/OPq, zero otherwise
  always_comb begin
    alu_b_s = {DATA_W{1'b0}};
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b_s = E_ValB;
      default:                                                   alu_b_s = {DATA_W{1'b0}};
    endcase
  end

  assign alufun_s = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  alu64 #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_a  (alu_a_s),
    .alu_b  (alu_b_s),
    .alufun (alufun_s),
    .res    (alu_res_s),
    .zf     (zf_s),
    .sf     (sf_s),
    .of     (of_s)
  );

  // Only OPq writes flags, and never while a younger-stage exception is pending
  assign set_cc_s = (E_icode == I_OPQ) && !is_exception(m_stat) && !is_exception(W_stat);

  // Condition code register; reset wins over an update in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r <= CC_RST;
    end else if (set_cc_s) begin
      cc_r <= {zf_s, sf_s, of_s};
    end else begin
      cc_r <= cc_r;
    end
  end

  // Condition evaluation against the current flags {ZF,SF,OF}
  always_comb begin
    cnd_s = 1'b0;
    case (E_ifun)
      C_YES:   cnd_s = 1'b1;
      C_LE:    cnd_s = (cc_r[1] ^ cc_r[0]) | cc_r[2];
      C_L:     cnd_s = cc_r[1] ^ cc_r[0];
      C_E:     cnd_s = cc_r[2];
      C_NE:    cnd_s = ~cc_r[2];
      C_GE:    cnd_s = ~(cc_r[1] ^ cc_r[0]);
      C_G:     cnd_s = ~(cc_r[1] ^ cc_r[0]) & ~cc_r[2];
      default: cnd_s = 1'b0;
    endcase
  end

  assign e_ValE  = alu_res_s;
  assign e_ValA  = E_ValA;
  assign e_Cnd   = cnd_s;
  // A failed conditional move must not write its destination
  assign e_dstE  = ((E_icode == I_RRMOVQ) && !cnd_s) ? RNONE : E_dstE;
  assign e_dstM  = E_dstM;
  assign e_stat  = E_stat;
  assign e_icode = E_icode;
  assign CC      = cc_r;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: each step drives the E register,
// pushes the hand-derived expected outputs, and the test pops and compares
// at the following falling edge.
module tb_execute_stage;
  import y86_pkg::*;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
  logic [DATA_W-1:0] E_ValC, E_ValA, E_ValB;
  logic [DATA_W-1:0] e_ValE, e_ValA;
  logic              e_Cnd;
  logic [3:0]        e_dstE, e_dstM, e_stat, e_icode;
  logic [2:0]        CC;

  typedef struct {
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_a;
    logic              cnd;
    logic [3:0]        dst_e;
    logic [2:0]        cc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(DATA_W), .CC_RST(3'b100)) dut (
    .clk(clk), .rst(rst),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_ValC(E_ValC), .E_ValA(E_ValA), .E_ValB(E_ValB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .e_ValE(e_ValE), .e_ValA(e_ValA), .e_Cnd(e_Cnd),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat),
    .e_icode(e_icode), .CC(CC)
  );

  // Drive one instruction into E and record what the stage must produce
  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] dste, input logic [63:0] x_vale,
                       input logic x_cnd, input logic [3:0] x_dste, input logic [2:0] x_cc);
    exp_t t;
    E_icode = icode; E_ifun = ifun; E_ValA = a; E_ValB = b; E_ValC = c;
    E_dstE = dste; E_dstM = 4'h5;
    t.val_e = x_vale; t.val_a = a; t.cnd = x_cnd; t.dst_e = x_dste; t.cc = x_cc;
    sb.push_back(t);
  endtask

  task automatic sample;
    @(negedge clk);
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=0 entries required>=1");
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; E_stat = S_AOK; m_stat = S_AOK; W_stat = S_AOK;
    drive(I_OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3,
          64'h8000_0000_0000_0000, 1'b1, 4'h3, 3'b100);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL reset_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    rst = 1'b0;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL reset_cc got=%b required=%b", CC, e.cc); end
    checks++;
    if (e_Cnd !== e.cnd) begin failures++; $display("FAIL reset_bubble_cnd got=%b required=%b", e_Cnd, e.cnd); end
    checks++;
    next_cycle;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL bubble_holds_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
  endtask

  task automatic test_add_overflow;
    drive(I_OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3,
          64'h8000_0000_0000_0000, 1'b1, 4'h3, 3'b100);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL add_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    if (e_dstE !== e.dst_e) begin failures++; $display("FAIL add_dste got=%h required=%h", e_dstE, e.dst_e); end
    checks++;
    if (e_ValA !== e.val_a) begin failures++; $display("FAIL add_vala got=%h required=%h", e_ValA, e.val_a); end
    checks++;
    next_cycle;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b011);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL add_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
  endtask

  task automatic test_sub_branch;
    // CC is 011 on entry: le = (1^1)|0 = 0
    drive(I_OPQ, ALU_SUB, 64'h5, 64'h5, 64'h0, 4'h3, 64'h0, 1'b0, 4'h3, 3'b011);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL sub_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    if (e_Cnd !== e.cnd) begin failures++; $display("FAIL sub_cnd_le got=%b required=%b", e_Cnd, e.cnd); end
    checks++;
    next_cycle;
    drive(I_JXX, C_E, 64'h0, 64'h0, 64'h40, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL sub_cc got=%b required=%b", CC, e.cc); end
    checks++;
    if (e_Cnd !== e.cnd) begin failures++; $display("FAIL je_cnd got=%b required=%b", e_Cnd, e.cnd); end
    checks++;
    next_cycle;
    drive(I_JXX, C_NE, 64'h0, 64'h0, 64'h40, RNONE, 64'h0, 1'b0, RNONE, 3'b100);
    sample;
    if (e_Cnd !== e.cnd) begin failures++; $display("FAIL jne_cnd got=%b required=%b", e_Cnd, e.cnd); end
    checks++;
    next_cycle;
  endtask

  task automatic test_sub_overflow_conds;
    logic [3:0] fns  [0:8];
    logic       cnds [0:8];
    // 0x8000.. - 1 = 0x7FFF..: ZF=0 SF=0 OF=1
    drive(I_OPQ, ALU_SUB, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h4,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'h4, 3'b100);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL subov_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    // With CC=001 (S^O=1, ZF=0)
    fns  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};
    cnds = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(I_JXX, fns[i], 64'h0, 64'h0, 64'h80, RNONE, 64'h0, cnds[i], RNONE, 3'b001);
      sample;
      if (CC !== e.cc) begin failures++; $display("FAIL cond_cc ifun=%0d got=%b required=%b", fns[i], CC, e.cc); end
      checks++;
      if (e_Cnd !== e.cnd) begin failures++; $display("FAIL cond ifun=%0d got=%b required=%b", fns[i], e_Cnd, e.cnd); end
      checks++;
      next_cycle;
    end
  endtask

  task automatic test_and_invalid;
    drive(I_OPQ, ALU_AND, 64'h8000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FF0F, 64'h0, 4'h2,
          64'h8000_0000_0000_000F, 1'b1, 4'h2, 3'b001);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL and_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    drive(I_OPQ, 4'h7, 64'h5, 64'h3, 64'h0, 4'h2, 64'h0, 1'b0, 4'h2, 3'b010);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL and_cc got=%b required=%b", CC, e.cc); end
    checks++;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL badfun_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL badfun_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
  endtask

  task automatic test_cmov;
    drive(I_OPQ, ALU_ADD, 64'h1, 64'h1, 64'h0, 4'h1, 64'h2, 1'b1, 4'h1, 3'b100);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL add2_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    drive(I_RRMOVQ, C_L, 64'hABCD, 64'h999, 64'h0, 4'h3, 64'hABCD, 1'b0, RNONE, 3'b000);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL cmov_cc got=%b required=%b", CC, e.cc); end
    checks++;
    if (e_Cnd !== e.cnd) begin failures++; $display("FAIL cmovl_cnd got=%b required=%b", e_Cnd, e.cnd); end
    checks++;
    if (e_dstE !== e.dst_e) begin failures++; $display("FAIL cmovl_dste got=%h required=%h", e_dstE, e.dst_e); end
    checks++;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL cmovl_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    if (e_dstM !== 4'h5) begin failures++; $display("FAIL cmovl_dstm got=%h required=5", e_dstM); end
    checks++;
    next_cycle;
    drive(I_RRMOVQ, C_YES, 64'hABCD, 64'h999, 64'h0, 4'h3, 64'hABCD, 1'b1, 4'h3, 3'b000);
    sample;
    if (e_dstE !== e.dst_e) begin failures++; $display("FAIL rrmov_dste got=%h required=%h", e_dstE, e.dst_e); end
    checks++;
    if (e_icode !== I_RRMOVQ) begin failures++; $display("FAIL rrmov_icode got=%h required=2", e_icode); end
    checks++;
    next_cycle;
  endtask

  task automatic test_cc_gating;
    m_stat = S_ADR;
    drive(I_OPQ, ALU_XOR, 64'h5, 64'h5, 64'h0, 4'h6, 64'h0, 1'b0, 4'h6, 3'b000);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL xor_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    m_stat = S_AOK; W_stat = S_HLT;
    drive(I_OPQ, ALU_XOR, 64'h5, 64'h5, 64'h0, 4'h6, 64'h0, 1'b0, 4'h6, 3'b000);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL mstat_adr_blocks_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
    W_stat = S_AOK; E_stat = S_INS;
    drive(I_OPQ, ALU_XOR, 64'h5, 64'h5, 64'h0, 4'h6, 64'h0, 1'b0, 4'h6, 3'b000);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL wstat_hlt_blocks_cc got=%b required=%b", CC, e.cc); end
    checks++;
    if (e_stat !== S_INS) begin failures++; $display("FAIL estat_pass got=%h required=4", e_stat); end
    checks++;
    next_cycle;
    E_stat = S_AOK;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL estat_no_gate_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
  endtask

  task automatic test_stack;
    drive(I_PUSHQ, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 64'hF8, 1'b1, 4'h4, 3'b100);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL pushq_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    next_cycle;
    drive(I_POPQ, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 64'h8, 1'b1, 4'h4, 3'b100);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL popq_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    if (CC !== e.cc) begin failures++; $display("FAIL pushq_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL popq_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
  endtask

  task automatic test_reset_mid;
    drive(I_OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3,
          64'h8000_0000_0000_0000, 1'b1, 4'h3, 3'b100);
    sample;
    next_cycle;
    rst = 1'b1;
    drive(I_OPQ, ALU_ADD, 64'h1, 64'h1, 64'h0, 4'h1, 64'h2, 1'b1, 4'h1, 3'b011);
    sample;
    if (e_ValE !== e.val_e) begin failures++; $display("FAIL midrst_vale got=%h required=%h", e_ValE, e.val_e); end
    checks++;
    if (CC !== e.cc) begin failures++; $display("FAIL midrst_cc_before got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
    rst = 1'b0;
    drive(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, RNONE, 64'h0, 1'b1, RNONE, 3'b100);
    sample;
    if (CC !== e.cc) begin failures++; $display("FAIL midrst_priority_cc got=%b required=%b", CC, e.cc); end
    checks++;
    next_cycle;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_branch;
    test_sub_overflow_conds;
    test_and_invalid;
    test_cmov;
    test_cc_gating;
    test_stack;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
